lsu_mem_master: RTL and testbench



---
 rtl/lsu_mem_master_pkg.sv | 32 +++
 rtl/lsu_lane_align.sv | 61 ++++++
 rtl/lsu_mem_master.sv | 171 +++++++++++++++++
 tb/tb_lsu_mem_master.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_master_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | lsu_mem_master_pkg: access-size encodings and FSM states shared by the  |
// | LSU initiator and its memory responder.                  Rev 1.0       |
// +------------------------------------------------------------------------+
package lsu_mem_master_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Bit of req_type that selects zero-extension on loads.
  localparam int TYPE_UNSIGNED_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: access_bad = 1'b0;
      SZ_HALF: access_bad = addr_lo[0];
      SZ_WORD: access_bad = (addr_lo != 2'b00);
      default: access_bad = 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | lsu_lane_align: store strobe/lane replication and load lane extract    |
// | with sign/zero extension.                                Rev 1.0       |
// +------------------------------------------------------------------------+
module lsu_lane_align
  import lsu_mem_master_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wstrb_o  = 4'b0000;
    wdata_o  = 32'h0;
    rdata_o  = 32'h0;
    byte_sel = 8'h0;
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (addr_lo_i)
      2'b00:   byte_sel = rdata_i[7:0];
      2'b01:   byte_sel = rdata_i[15:8];
      2'b10:   byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase

    case (size_i)
      SZ_BYTE: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        wstrb_o = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: begin
        wstrb_o = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | lsu_mem_master: data-side load/store initiator with misalignment       |
// | detection and a bounded wait for the memory response.    Rev 1.0       |
// +------------------------------------------------------------------------+
module lsu_mem_master
  import lsu_mem_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wr,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [3:0]        mem_req_wstrb,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata
);

  localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // WAIT lasts TIMEOUT-1 cycles: the abort fires as the count steps to TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        alo_q, alo_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              in_idle;
  logic [1:0]        al_size, al_alo;
  logic              al_uns;
  logic [3:0]        al_wstrb;
  logic [31:0]       al_wdata, al_rdata;

  // The aligner serves the store path while accepting and the load path afterwards.
  assign in_idle = (state_q == ST_IDLE);
  assign al_size = in_idle ? req_type[1:0] : size_q;
  assign al_uns  = in_idle ? req_type[TYPE_UNSIGNED_BIT] : uns_q;
  assign al_alo  = in_idle ? req_addr[1:0] : alo_q;

  lsu_lane_align u_align (
    .size_i     (al_size),
    .unsigned_i (al_uns),
    .addr_lo_i  (al_alo),
    .wdata_i    (req_wdata),
    .rdata_i    (mem_resp_rdata),
    .wstrb_o    (al_wstrb),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    alo_d   = alo_q;
    maddr_d = maddr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          size_d  = req_type[1:0];
          uns_d   = req_type[TYPE_UNSIGNED_BIT];
          alo_d   = req_addr[1:0];
          maddr_d = {req_addr[ADDR_W-1:2], 2'b00};
          wstrb_d = req_wr ? al_wstrb : 4'b0000;
          wdata_d = req_wr ? al_wdata : 32'h0;
          rdata_d = 32'h0;
          if (access_bad(req_type[1:0], req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_resp_valid) begin
          rdata_d = wr_q ? 32'h0 : al_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      alo_q   <= 2'b00;
      maddr_q <= '0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      alo_q   <= alo_d;
      maddr_q <= maddr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready     = in_idle;
  assign resp_valid    = (state_q == ST_RESP);
  assign resp_rdata    = resp_valid ? rdata_q : 32'h0;
  assign resp_err      = resp_valid & err_q;
  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_req_wr    = wr_q;
  assign mem_req_addr  = maddr_q;
  assign mem_req_wstrb = wstrb_q;
  assign mem_req_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_lsu_mem_master: directed load/store vectors against hand-computed   |
// | results, with a scripted memory responder.               Rev 1.0       |
// +------------------------------------------------------------------------+
module tb_lsu_mem_master;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wr;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int checks   = 0;
  int failures = 0;

  // Results of the most recent run_txn call.
  int          t_lat, t_hs;
  logic [31:0] t_rdata, t_maddr, t_wdata;
  logic [3:0]  t_wstrb;
  logic        t_err, t_saw, t_mwr, t_stable;

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wr         (req_wr),
    .req_type       (req_type),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_wr     (mem_req_wr),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge and play the responder: ready after rdy_wait
  // REQ cycles, response rsp_wait cycles into WAIT (rsp_wait<0: never answer).
  task automatic run_txn(input logic wr, input logic [2:0] typ, input logic [31:0] addr,
                         input logic [31:0] wdata, input int rdy_wait, input int rsp_wait,
                         input logic [31:0] rdata);
    int n, r;
    logic done;
    @(negedge clk);
    check_val("rdy_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_wr = wr; req_type = typ; req_addr = addr; req_wdata = wdata;
    n = 0; r = 0; done = 1'b0;
    t_hs = -1; t_saw = 1'b0; t_stable = 1'b1; t_lat = -1;
    t_rdata = 32'hx; t_err = 1'bx;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
      if (resp_valid) begin
        t_lat = n; t_rdata = resp_rdata; t_err = resp_err; done = 1'b1;
      end else if (mem_req_valid) begin
        if (!t_saw) begin
          t_saw = 1'b1; t_maddr = mem_req_addr; t_wstrb = mem_req_wstrb;
          t_wdata = mem_req_wdata; t_mwr = mem_req_wr;
        end else if (mem_req_addr !== t_maddr || mem_req_wstrb !== t_wstrb ||
                     mem_req_wdata !== t_wdata || mem_req_wr !== t_mwr) begin
          t_stable = 1'b0;
        end
        if (r == rdy_wait) begin
          mem_req_ready = 1'b1; t_hs = n;
        end
        r++;
      end else if (t_hs >= 0 && rsp_wait >= 0 && (n - t_hs) == rsp_wait + 1) begin
        mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
      end
    end
    check_val("txn_done", {31'h0, done}, 32'h1);
    @(negedge clk);
    check_val("pulse_1cyc", {31'h0, resp_valid}, 32'h0);
    check_val("rdata_idle0", resp_rdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_type = 3'b000; req_addr = 32'h0;
    req_wdata = 32'h0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check_val("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check_val("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check_val("rst_resp_rdata", resp_rdata, 32'h0);
    check_val("rst_mreq_valid", {31'h0, mem_req_valid}, 32'h0);
    check_val("rst_mreq_wr", {31'h0, mem_req_wr}, 32'h0);
    check_val("rst_mreq_addr", mem_req_addr, 32'h0);
    check_val("rst_mreq_wstrb", {28'h0, mem_req_wstrb}, 32'h0);
    check_val("rst_mreq_wdata", mem_req_wdata, 32'h0);

    // Signed byte load from lane 3, zero-wait responder.
    run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 0, 32'h80AA_BBCC);
    check_val("lb_rdata", t_rdata, 32'hFFFF_FF80);
    check_val("lb_err", {31'h0, t_err}, 32'h0);
    check_val("lb_lat", t_lat, 32'd3);
    check_val("lb_maddr", t_maddr, 32'h0000_0100);
    check_val("lb_wstrb", {28'h0, t_wstrb}, 32'h0);
    check_val("lb_mwr", {31'h0, t_mwr}, 32'h0);

    // Upper half, unsigned then signed.
    run_txn(1'b0, 3'b101, 32'h0000_0202, 32'h0, 0, 0, 32'h9234_5678);
    check_val("lhu_rdata", t_rdata, 32'h0000_9234);
    check_val("lhu_maddr", t_maddr, 32'h0000_0200);
    run_txn(1'b0, 3'b001, 32'h0000_0202, 32'h0, 0, 0, 32'h9234_5678);
    check_val("lh_rdata", t_rdata, 32'hFFFF_9234);

    // Word load ignores the unsigned flag; two-cycle response delay.
    run_txn(1'b0, 3'b110, 32'h0000_0404, 32'h0, 0, 2, 32'h8765_4321);
    check_val("lw_rdata", t_rdata, 32'h8765_4321);
    check_val("lw_lat", t_lat, 32'd5);

    // Stores: ack carries garbage read data that must not leak out.
    run_txn(1'b1, 3'b000, 32'h0000_0301, 32'h1234_56A5, 0, 0, 32'hDEAD_BEEF);
    check_val("sb_maddr", t_maddr, 32'h0000_0300);
    check_val("sb_wstrb", {28'h0, t_wstrb}, 32'h2);
    check_val("sb_wdata", t_wdata, 32'hA5A5_A5A5);
    check_val("sb_mwr", {31'h0, t_mwr}, 32'h1);
    check_val("sb_rdata", t_rdata, 32'h0);
    check_val("sb_err", {31'h0, t_err}, 32'h0);
    run_txn(1'b1, 3'b001, 32'h0000_0302, 32'hFFFF_1234, 0, 0, 32'hDEAD_BEEF);
    check_val("sh_wstrb", {28'h0, t_wstrb}, 32'hC);
    check_val("sh_wdata", t_wdata, 32'h1234_1234);
    check_val("sh_rdata", t_rdata, 32'h0);
    check_val("sh_lat", t_lat, 32'd3);

    // Misaligned word and illegal size: no memory request, 1-cycle error.
    run_txn(1'b0, 3'b010, 32'h0000_0401, 32'h0, 0, 0, 32'h1111_1111);
    check_val("mis_saw", {31'h0, t_saw}, 32'h0);
    check_val("mis_lat", t_lat, 32'd1);
    check_val("mis_err", {31'h0, t_err}, 32'h1);
    check_val("mis_rdata", t_rdata, 32'h0);
    run_txn(1'b0, 3'b011, 32'h0000_0400, 32'h0, 0, 0, 32'h1111_1111);
    check_val("ill_saw", {31'h0, t_saw}, 32'h0);
    check_val("ill_lat", t_lat, 32'd1);
    check_val("ill_err", {31'h0, t_err}, 32'h1);

    // Ready held low 5 cycles, responder silent: timeout TIMEOUT cycles after handshake.
    run_txn(1'b0, 3'b010, 32'h0000_0600, 32'h0, 5, -1, 32'h0);
    check_val("to_stable", {31'h0, t_stable}, 32'h1);
    check_val("to_hs", t_hs, 32'd6);
    check_val("to_delta", t_lat - t_hs, TIMEOUT);
    check_val("to_err", {31'h0, t_err}, 32'h1);
    check_val("to_rdata", t_rdata, 32'h0);
    // Late response and stray ready in IDLE are ignored.
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    check_val("late_resp_valid", {31'h0, resp_valid}, 32'h0);
    check_val("late_mreq_valid", {31'h0, mem_req_valid}, 32'h0);
    check_val("late_req_ready", {31'h0, req_ready}, 32'h1);

    // Response in the very cycle the timeout would fire: response wins.
    run_txn(1'b0, 3'b100, 32'h0000_0101, 32'h0, 0, TIMEOUT - 2, 32'h1122_F033);
    check_val("race_err", {31'h0, t_err}, 32'h0);
    check_val("race_rdata", t_rdata, 32'h0000_00F0);
    check_val("race_lat", t_lat, TIMEOUT + 1);

    // Reset during WAIT drops the transaction.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_type = 3'b010; req_addr = 32'h0000_0500;
    @(negedge clk);
    req_valid = 1'b0;
    check_val("rw_mreq_valid", {31'h0, mem_req_valid}, 32'h1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rw_req_ready", {31'h0, req_ready}, 32'h1);
    check_val("rw_resp_valid", {31'h0, resp_valid}, 32'h0);
    check_val("rw_mreq_valid0", {31'h0, mem_req_valid}, 32'h0);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      check_val("rw_no_resp", {31'h0, resp_valid}, 32'h0);
    end
    run_txn(1'b0, 3'b010, 32'h0000_0504, 32'h0, 0, 0, 32'h0BAD_CAFE);
    check_val("post_rst_rdata", t_rdata, 32'h0BAD_CAFE);
    check_val("post_rst_lat", t_lat, 32'd3);
    check_val("post_rst_err", {31'h0, t_err}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
